// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI3 SRAM slave: response and burst codes,
// read/write FSM state encodings and the beat-counter width.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  // Only arlen/awlen[3:0] are honoured, so bursts are at most 16 beats.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DLY  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_sram_mem.sv
// Byte-enable 32-bit word RAM with one write port and one registered read port.
// A read and a write to the same word on the same edge return the old data.
// Ports:
//   clk          clock
//   we/waddr     write enable and word address
//   wdata/wstrb  write data and byte enables
//   re/raddr     read enable and word address
//   rdata        registered read data, holds while re=0
module axi_sram_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave responder backed by on-chip word RAM. Independent read and write
// engines, each with at most one outstanding transaction.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ar*/r*                     AXI3 read address and read data channels
//   aw*/w*/b*                  AXI3 write address, write data and response
//   arlock/arcache/arprot,
//   awlock/awcache/awprot, wid accepted but ignored
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready=1, waiting for an AR handshake
//   R_DLY  | counting RD_DELAY idle cycles before the first beat
//   R_DATA | rvalid=0: fetching first beat; rvalid=1: presenting beats
// Write FSM
//   state  | meaning
//   W_IDLE | awready=1, waiting for an AW handshake
//   W_DATA | wready=1, accepting beats until count==0 or wlast
//   W_RESP | bvalid=1, waiting for bready
module axi_sram_slave #(
  parameter int MEM_AW   = 12,
  parameter int RD_DELAY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  import axi_sram_pkg::*;

  // R_DLY counts down to zero, so it is loaded with RD_DELAY-1.
  localparam logic [3:0] DLY_INIT = (RD_DELAY > 0) ? 4'(RD_DELAY - 1) : 4'd0;

  logic unused_ok;
  assign unused_ok = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       araddr[31:MEM_AW+2], araddr[1:0], arlen[7:CNT_W],
                       awaddr[31:MEM_AW+2], awaddr[1:0], awlen[7:CNT_W]};

  // ---------------- read engine ----------------
  rd_state_t         rd_state;
  logic [3:0]        r_id;
  logic [MEM_AW-1:0] r_addr;
  logic [MEM_AW-1:0] r_addr_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fixed;
  logic              r_err;
  logic [3:0]        r_dly;

  logic              mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic [31:0]       mem_rdata;

  assign r_addr_nxt = r_fixed ? r_addr : r_addr + MEM_AW'(1);

  // First beat is fetched on the cycle R_DATA is entered; later beats are
  // fetched on the handshake edge so they appear back-to-back.
  assign mem_re    = (rd_state == R_DATA) && (!rvalid || (rready && (r_cnt != '0)));
  assign mem_raddr = rvalid ? r_addr_nxt : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_fixed  <= 1'b0;
      r_err    <= 1'b0;
      r_dly    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready  <= 1'b0;
            r_id     <= arid;
            r_addr   <= araddr[MEM_AW+1:2];
            r_cnt    <= arlen[CNT_W-1:0];
            r_fixed  <= (arburst == BURST_FIXED);
            r_err    <= (arsize > 3'd2);
            r_dly    <= DLY_INIT;
            rd_state <= (RD_DELAY > 0) ? R_DLY : R_DATA;
          end
        end
        R_DLY: begin
          if (r_dly == '0) rd_state <= R_DATA;
          else             r_dly    <= r_dly - 4'd1;
        end
        R_DATA: begin
          if (!rvalid) begin
            rvalid <= 1'b1;
          end else if (rready) begin
            if (r_cnt == '0) begin
              rvalid   <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt - CNT_W'(1);
              r_addr <= r_addr_nxt;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign rid   = r_id;
  assign rdata = (rvalid && !r_err) ? mem_rdata : 32'd0;
  assign rresp = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && (r_cnt == '0);

  // ---------------- write engine ----------------
  wr_state_t         wr_state;
  logic [MEM_AW-1:0] w_addr;
  logic [MEM_AW-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_fixed;
  logic              w_serr;
  logic              w_cnt_zero;
  logic              mem_we;

  assign w_addr_nxt = w_fixed ? w_addr : w_addr + MEM_AW'(1);
  assign w_cnt_zero = (w_cnt == '0);
  // Bursts with an unsupported size are answered with SLVERR and leave RAM untouched.
  assign mem_we     = wvalid && wready && !w_serr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      w_addr   <= '0;
      w_cnt    <= '0;
      w_fixed  <= 1'b0;
      w_serr   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            w_addr   <= awaddr[MEM_AW+1:2];
            w_cnt    <= awlen[CNT_W-1:0];
            w_fixed  <= (awburst == BURST_FIXED);
            w_serr   <= (awsize > 3'd2);
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            // A wlast/count disagreement can only show up on the terminating
            // beat, so the error is resolved there.
            if (wlast || w_cnt_zero) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (w_serr || (wlast != w_cnt_zero)) ? RESP_SLVERR : RESP_OKAY;
              wr_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt - CNT_W'(1);
              w_addr <= w_addr_nxt;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  axi_sram_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arvalid2, rready2;

  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        arready2, rlast2, rvalid2, awready2, wready2, bvalid2;
  logic [3:0]  rid2, bid2;
  logic [31:0] rdata2;
  logic [1:0]  rresp2, bresp2;

  axi_sram_slave #(.MEM_AW(MEM_AW), .RD_DELAY(0)) dut (
    .clk(clk), .reset(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b0), .arcache(4'h0), .arprot(3'b0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b0), .awcache(4'h0), .awprot(3'b0), .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready));

  // Second instance only exercises the RD_DELAY latency; writes are shared.
  axi_sram_slave #(.MEM_AW(MEM_AW), .RD_DELAY(2)) dut_dly (
    .clk(clk), .reset(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b0), .arcache(4'h0), .arprot(3'b0), .arvalid(arvalid2), .arready(arready2),
    .rid(rid2), .rdata(rdata2), .rresp(rresp2), .rlast(rlast2), .rvalid(rvalid2), .rready(rready2),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b0), .awcache(4'h0), .awprot(3'b0), .awvalid(awvalid), .awready(awready2),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready2),
    .bid(bid2), .bresp(bresp2), .bvalid(bvalid2), .bready(bready));

  // Reference model: plain word array indexed modulo the memory depth.
  logic [31:0] model [DEPTH];
  logic [31:0] wq_d[$];
  logic [3:0]  wq_s[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Write burst from wq_d/wq_s; early>=0 puts wlast on that beat.
  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input int early,
                          output logic [1:0] br);
    int n, nb, w, g;
    logic [1:0] want;
    n  = (len % 16) + 1;
    nb = (early >= 0 && early < n - 1) ? early + 1 : n;
    w  = int'(addr >> 2) % DEPTH;
    want = (size > 3'd2 || nb != n) ? 2'd2 : 2'd0;
    awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
    g = 0;
    while (!awready && g < 64) begin tick(); g++; end
    if (g >= 64) timeout("aw_handshake");
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = wq_d[i]; wstrb = wq_s[i]; wlast = (i == nb - 1); wvalid = 1'b1;
      g = 0;
      while (!wready && g < 64) begin tick(); g++; end
      if (g >= 64) timeout("w_handshake");
      tick();
      if (size <= 3'd2)
        for (int b = 0; b < 4; b++)
          if (wq_s[i][b]) model[w][8*b +: 8] = wq_d[i][8*b +: 8];
      if (burst != 2'd0) w = (w + 1) % DEPTH;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_ready_after_last", 32'(wready), 0);
    check("b_valid_after_last", 32'(bvalid), 1);
    repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1;
    g = 0;
    while (!bvalid && g < 64) begin tick(); g++; end
    if (g >= 64) timeout("b_handshake");
    check("b_id", 32'(bid), 32'(id));
    check("b_resp", 32'(bresp), 32'(want));
    br = bresp;
    tick();
    bready = 1'b0;
    check("b_done_awready", 32'({bvalid, awready}), 32'(2'b01));
  endtask

  // Read burst, every beat checked against the model; pattern or random rready.
  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input bit use_pat,
                          input logic [15:0] pat, output logic [31:0] d0, output logic [1:0] r0);
    int n, w, g, k, beat, lat;
    bit err, seen, stalled, rr;
    logic [40:0] held;
    n = (len % 16) + 1;
    w = int'(addr >> 2) % DEPTH;
    err = (size > 3'd2);
    seen = 0; stalled = 0; k = 0; beat = 0; lat = 0; held = '0;
    araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 64) begin tick(); g++; end
    if (g >= 64) timeout("ar_handshake");
    tick();
    arvalid = 1'b0;
    g = 0;
    while (beat < n && g < 200) begin
      rready = 1'b0;
      if (rvalid) begin
        if (!seen) check("r_first_latency", 32'(lat), 1);
        seen = 1;
        if (stalled) check("r_stall_hold", 32'({rdata[31:0], rid, rresp, rlast} ^ held), 0);
        rr = use_pat ? ((k < 16) ? pat[k] : 1'b1) : ($urandom_range(0, 3) != 0);
        k++;
        rready = rr;
        if (rr) begin
          check("r_data", rdata, err ? 32'd0 : model[w]);
          check("r_resp", 32'(rresp), err ? 32'd2 : 32'd0);
          check("r_last", 32'(rlast), 32'(beat == n - 1));
          check("r_id", 32'(rid), 32'(id));
          if (beat == 0) begin d0 = rdata; r0 = rresp; end
          beat++;
          if (burst != 2'd0) w = (w + 1) % DEPTH;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {rdata, rid, rresp, rlast};
        end
      end
      tick();
      lat++; g++;
    end
    rready = 1'b0;
    if (beat < n) timeout("r_beats");
    check("r_end_state", 32'({rvalid, arready}), 32'(2'b01));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, oldv, newv;
    logic [1:0]  r;
    int g;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 3'd2, 4'd2, 32'h0,        2'd0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 3'd2, 4'd1, 32'hDEADBEEF, 2'd0};
    tbl[2]  = '{1'b1, 32'h0000_0010, 32'h12345678, 4'h3, 3'd2, 4'd3, 32'h0,        2'd0};
    tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 3'd2, 4'd1, 32'hDEAD5678, 2'd0};
    tbl[4]  = '{1'b1, 32'h0000_4012, 32'h0000AB00, 4'h2, 3'd2, 4'd5, 32'h0,        2'd0};
    tbl[5]  = '{1'b0, 32'hFFFF_C010, 32'h0,        4'h0, 3'd1, 4'd6, 32'hDEADAB78, 2'd0};
    tbl[6]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 3'd3, 4'd7, 32'h0,        2'd2};
    tbl[7]  = '{1'b1, 32'h0000_0014, 32'hCAFEF00D, 4'hF, 3'd2, 4'd9, 32'h0,        2'd0};
    tbl[8]  = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 3'd0, 4'd8, 32'hCAFEF00D, 2'd0};
    tbl[9]  = '{1'b1, 32'h0000_0014, 32'hFFFFFFFF, 4'h0, 3'd2, 4'd4, 32'h0,        2'd0};
    tbl[10] = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 3'd2, 4'd0, 32'hCAFEF00D, 2'd0};

    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0; arvalid2 = 0; rready2 = 0;

    // Reset behaviour and release.
    #1 rst = 1'b1;
    repeat (3) tick();
    check("rst_outputs_zero", 32'({arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp}), 0);
    rst = 1'b0;
    check("rst_release_before_edge", 32'({arready, awready}), 0);
    tick();
    check("rst_ready_rise", 32'({arready, awready}), 32'(2'b11));
    check("rst_valids_low", 32'({rvalid, bvalid}), 0);

    // Table of single-beat transactions with hand-computed results.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) begin
        wq_d = {tbl[i].data}; wq_s = {tbl[i].strb};
        wr_burst(tbl[i].addr, 0, 2'd1, tbl[i].size, tbl[i].id, -1, r);
        check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
      end else begin
        rd_burst(tbl[i].addr, 0, 2'd1, tbl[i].size, tbl[i].id, 1'b0, 16'hFFFF, d, r);
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
        check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
      end
    end

    // Preload words 0..63 with random data, then words 0..3 with A0..A3.
    for (int b = 0; b < 4; b++) begin
      wq_d = {}; wq_s = {};
      for (int i = 0; i < 16; i++) begin wq_d.push_back($urandom); wq_s.push_back(4'hF); end
      wr_burst(32'(b * 64), 15, 2'd1, 3'd2, 4'd0, -1, r);
    end
    wq_d = {32'hA0, 32'hA1, 32'hA2, 32'hA3}; wq_s = {4'hF, 4'hF, 4'hF, 4'hF};
    wr_burst(32'h0, 3, 2'd1, 3'd2, 4'd1, -1, r);

    // INCR burst with rready pattern 1,0,0,1,1,0,1.
    rd_burst(32'h0, 3, 2'd1, 3'd2, 4'd3, 1'b1, 16'hFFD9, d, r);
    check("incr_first_beat", d, 32'hA0);

    // Early wlast: 4-beat burst terminated on beat 1.
    wq_d = {32'hE0, 32'hE1, 32'hE2, 32'hE3}; wq_s = {4'hF, 4'hF, 4'hF, 4'hF};
    oldv = model[22];
    wr_burst(32'h50, 3, 2'd1, 3'd2, 4'd6, 1, r);
    check("early_wlast_bresp", 32'(r), 2);
    rd_burst(32'h58, 0, 2'd1, 3'd2, 4'd2, 1'b0, 16'hFFFF, d, r);
    check("early_wlast_untouched", d, oldv);
    rd_burst(32'h50, 3, 2'd1, 3'd2, 4'd2, 1'b0, 16'hFFFF, d, r);

    // Address wraps from the top word to word 0.
    wq_d = {32'h11111111, 32'h22222222}; wq_s = {4'hF, 4'hF};
    wr_burst(32'h3FFC, 1, 2'd1, 3'd2, 4'd7, -1, r);
    rd_burst(32'h0, 0, 2'd1, 3'd2, 4'd7, 1'b0, 16'hFFFF, d, r);
    check("wrap_word0", d, 32'h22222222);
    rd_burst(32'h3FFC, 1, 2'd2, 3'd2, 4'd7, 1'b0, 16'hFFFF, d, r);

    // Same-edge read fetch and write of word 8: read sees old data.
    oldv = model[8]; newv = 32'h5A5A_C3C3;
    araddr = 32'h20; arlen = 0; arsize = 3'd2; arburst = 2'd1; arid = 4'd3; arvalid = 1'b1;
    awaddr = 32'h20; awlen = 0; awsize = 3'd2; awburst = 2'd1; awid = 4'd4; awvalid = 1'b1;
    wdata = newv; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    check("coll_both_ready", 32'({arready, awready}), 32'(2'b11));
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    check("coll_rvalid", 32'(rvalid), 1);
    check("coll_old_data", rdata, oldv);
    model[8] = newv;
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    rd_burst(32'h20, 0, 2'd1, 3'd2, 4'd5, 1'b0, 16'hFFFF, d, r);
    check("coll_new_data", d, newv);

    // RD_DELAY=2 instance: first rvalid three cycles after the AR handshake.
    araddr = 32'h50; arlen = 0; arsize = 3'd2; arburst = 2'd1; arid = 4'd6; arvalid2 = 1'b1;
    g = 0;
    while (!arready2 && g < 64) begin tick(); g++; end
    if (g >= 64) timeout("dly_ar_handshake");
    tick();
    arvalid2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("dly_rvalid_low_c%0d", c), 32'(rvalid2), 0);
      tick();
    end
    check("dly_rvalid_rise", 32'(rvalid2), 1);
    check("dly_rdata", rdata2, model[20]);
    check("dly_rid_rlast", 32'({rid2, rlast2}), 32'({4'd6, 1'b1}));
    rready2 = 1'b1;
    tick();
    rready2 = 1'b0;
    check("dly_end_state", 32'({rvalid2, arready2}), 32'(2'b01));

    // Random traffic over words 0..62 against the model.
    for (int t = 0; t < 40; t++) begin
      int base, len;
      logic [31:0] a;
      base = $urandom_range(0, 47);
      len  = $urandom_range(0, 255);
      a = {18'($urandom), 12'(base), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        wq_d = {}; wq_s = {};
        for (int i = 0; i < 16; i++) begin wq_d.push_back($urandom); wq_s.push_back(4'($urandom)); end
        wr_burst(a, len, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 4'($urandom), -1, r);
      end else begin
        rd_burst(a, len, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 4'($urandom),
                 1'b0, 16'hFFFF, d, r);
      end
    end

    // Reset asserted while beat 2 of a 4-beat burst is presented.
    araddr = 32'h0; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arid = 4'd9; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 64) begin tick(); g++; end
    tick();
    arvalid = 1'b0; rready = 1'b1;
    g = 0;
    while (!rvalid && g < 16) begin tick(); g++; end
    if (g >= 16) timeout("midrst_first_beat");
    tick();
    check("midrst_beat2", rdata, model[1]);
    #2 rst = 1'b1;
    #1;
    check("midrst_rvalid_async", 32'(rvalid), 0);
    check("midrst_rdata_async", rdata, 0);
    check("midrst_outs_async", 32'({arready, awready, wready, bvalid, rlast, rresp, rid, bid}), 0);
    rready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midrst_arready_back", 32'(arready), 1);
    rd_burst(32'h4, 1, 2'd1, 3'd2, 4'd10, 1'b0, 16'hFFFF, d, r);
    check("midrst_recovery", d, model[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
